// File: rtl/mem_line_ctrl.sv
// Line-transfer sequencer: one cache line write-back and/or refill becomes consecutive word
// accesses on a single-port memory with 1-cycle read latency. MEM_LINE_CTRL_STATS_EN adds transfer counters.
//
// state | meaning
// IDLE  | waiting for wr_req / rd_req, memory port quiet
// WB    | writing line words 0..N-1 (cnt = word)
// RF    | reading words 0..N-1, capturing each one cycle later (cnt 0..N)
// DONE  | transfer finished, gnt is registered out on the following cycle
`timescale 1ns/1ps
module mem_line_ctrl #(
    parameter int ADDR_LEN      = 11,
    parameter int LINE_ADDR_LEN = 3,
    localparam int TAG_ADDR_LEN = ADDR_LEN - LINE_ADDR_LEN,
    localparam int N            = 1 << LINE_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [TAG_ADDR_LEN-1:0] rd_line_addr,
    input  logic [TAG_ADDR_LEN-1:0] wr_line_addr,
    input  logic [32*N-1:0]         wr_line,
    output logic [32*N-1:0]         rd_line,
    output logic                    gnt,
    output logic [ADDR_LEN-1:0]     mem_addr,
    output logic                    mem_wr_req,
    output logic [31:0]             mem_wr_data,
    input  logic [31:0]             mem_rd_data
`ifdef MEM_LINE_CTRL_STATS_EN
    ,
    output logic [15:0]             wb_count,
    output logic [15:0]             rf_count
`endif
);

    localparam int CW = LINE_ADDR_LEN + 1;
    localparam logic [CW-1:0]            CNT_WB_LAST = CW'(N - 1);
    localparam logic [CW-1:0]            CNT_RF_LAST = CW'(N);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_RF,
        S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic [TAG_ADDR_LEN-1:0]  wr_tag_q, rd_tag_q;
    logic                     xfer_wb_q, xfer_rf_q;
    logic [LINE_ADDR_LEN-1:0] word_idx, cap_idx;
    logic [N-1:0][31:0]       wr_words;
    logic [N-1:0][31:0]       rd_words;

    assign wr_words = wr_line;
    assign rd_line  = rd_words;
    assign word_idx = cnt[LINE_ADDR_LEN-1:0];
    // read data lags its address by one cycle, so it lands in the previous word slot
    assign cap_idx  = word_idx - 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (wr_req) begin
                    state_nxt = S_WB;
                end else if (rd_req) begin
                    state_nxt = S_RF;
                end
            end
            S_WB: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {wr_tag_q, word_idx};
                mem_wr_data = wr_words[word_idx];
                if (cnt == CNT_WB_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = xfer_rf_q ? S_RF : S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RF: begin
                if (cnt == CNT_RF_LAST) begin
                    mem_addr  = {rd_tag_q, LAST_WORD};
                    state_nxt = S_DONE;
                end else begin
                    mem_addr = {rd_tag_q, word_idx};
                    cnt_nxt  = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            wr_tag_q  <= '0;
            rd_tag_q  <= '0;
            xfer_wb_q <= 1'b0;
            xfer_rf_q <= 1'b0;
            rd_words  <= '0;
            gnt       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt   <= (state == S_DONE);
            if (state == S_IDLE && (wr_req || rd_req)) begin
                if (wr_req) begin
                    wr_tag_q <= wr_line_addr;
                end
                rd_tag_q  <= rd_line_addr;
                xfer_wb_q <= wr_req;
                xfer_rf_q <= rd_req;
            end
            if (state == S_RF && cnt != '0) begin
                rd_words[cap_idx] <= mem_rd_data;
            end
        end
    end

`ifdef MEM_LINE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count <= '0;
            rf_count <= '0;
        end else if (state == S_DONE) begin
            if (xfer_wb_q) begin
                wb_count <= wb_count + 1'b1;
            end
            if (xfer_rf_q) begin
                rf_count <= rf_count + 1'b1;
            end
        end
    end
`endif

endmodule
